spi_fifo_port: RTL
==================

# spi_fifo_port

Byte-stream FIFO slave on the SPIGate internal register bus, alongside the IOPort8/IOPort16 slaves. It gives the SPI host two queues at one register address: writes feed an RX FIFO toward fabric logic, and reads drain a TX FIFO filled by fabric logic. Fabric-side traffic uses valid/ready streams. An optional status register reports FIFO levels and sticky error flags.

## Interface
Parameters:
- ADDRESS, 8'h10: data register address. The status register is at ADDRESS+1.
- DEPTH_LOG2, 4: log2 of the depth of each FIFO (16 entries).

Ports:
- CLK  in  1  system clock, the same clock as SPIGate.
- RST  in  1  reset, asynchronous and active-high.
- RXD  in  8  byte received from the host, valid during RXE.
- TXD  out  8  tristate bus byte toward the host. Driven only while ADDR matches a decoded address, 8'hzz otherwise.
- ADDR  in  8  current transaction register address.
- RXE  in  1  one-cycle write strobe: RXD is to be written to ADDR.
- TXE  in  1  one-cycle read strobe: the gate has latched TXD, so advance to the next byte.
- RX_DATA  out  8  head byte of the RX FIFO (first-word fall-through).
- RX_VALID  out  1  RX FIFO is not empty.
- RX_READY  in  1  fabric consumes RX_DATA when RX_VALID && RX_READY.
- TX_DATA  in  8  byte from fabric.
- TX_VALID  in  1  fabric offers TX_DATA.
- TX_READY  out  1  TX FIFO is not full. Push happens when TX_VALID && TX_READY.

## Operation
- Each FIFO is a DEPTH_LOG2-bit indexed RAM with a read pointer, a write pointer and a (DEPTH_LOG2+1)-bit count. Pointers wrap modulo 2^DEPTH_LOG2.
- Data register writes:
  - RXE with ADDR==ADDRESS pushes RXD into the RX FIFO.
  - If the FIFO is full and no fabric pop happens in the same cycle, the byte is dropped and rx_ovf (sticky) is set.
- Data register reads:
  - With ADDR==ADDRESS, TXD shows the TX FIFO head byte combinationally. It shows 8'h00 when the FIFO is empty.
  - TXE with ADDR==ADDRESS pops the TX FIFO. If it is empty, nothing is popped and tx_udf (sticky) is set.
- Simultaneous push and pop on the same FIFO:
  - Both take effect and the count is unchanged.
  - On a full RX FIFO, the push is accepted when a fabric pop happens in the same cycle.
  - On an empty TX FIFO, the pop is an underflow and the push still stores.
- Writes to ADDRESS+1 are ignored.
- RXE and TXE at any other ADDR are ignored, and TXD stays high-impedance.
- No internal state machine is visible on the bus: each strobe is handled entirely in the cycle it arrives.

## Timing
- Reset (asynchronous, while RST=1):
  - Pointers, counts, rx_ovf and tx_udf are cleared.
  - RX_VALID=0, TX_READY=1, RX_DATA=8'h00.
  - TXD follows the decode rules.
- Latency:
  - A byte pushed on RXE in cycle N appears on RX_DATA with RX_VALID=1 in cycle N+1.
  - A fabric push in cycle N is visible on TXD in cycle N+1.
- All flag and count updates are registered on the CLK rising edge. TXD decode and mux are combinational from ADDR and the registered state.
- Asserting RST mid-transaction discards all queued data immediately. The next strobe after release behaves as on an empty FIFO.

## Configuration
- FIFO_PORT_STATUS_EN defined: ADDRESS+1 decodes as a read-only status register.
  - Status byte: {tx_udf, rx_ovf, tx_full, tx_empty, rx_full, rx_empty, 2'b00}.
  - TXE at ADDRESS+1 clears rx_ovf and tx_udf. A flag event in the same cycle wins, so the flag stays set.
- FIFO_PORT_STATUS_EN undefined:
  - ADDRESS+1 is not decoded and TXD stays 8'hzz there.
  - The sticky flags are not implemented.
  - Overflow and underflow behave the same, except that no flag is recorded.

## Test plan
- Reset, then host writes 8'hA5, 8'h3C to ADDRESS with RX_READY=0 -> RX_VALID=1 one cycle after the first RXE. Raising RX_READY then yields A5 followed by 3C, and RX_VALID falls afterwards.
- Fabric pushes 8'h11..8'h1F (15 bytes) while the host reads 16 times at ADDRESS -> TXD shows 11..1F in order, then the 16th read returns 8'h00 and sets tx_udf. Status then reads bit7=1, bit4=1 (tx_empty), and the next status read shows bit7=0.
- Host writes 17 bytes 8'h00..8'h10 with RX_READY=0 and DEPTH_LOG2=4 -> first 16 stored, 8'h10 dropped, rx_ovf=1, RX_VALID stays 1, and the fabric drains 00..0F.
- RX FIFO full, with RXE and a fabric pop in the same cycle -> byte accepted, count stays 16, rx_ovf stays 0.
- RXE/TXE at ADDR=ADDRESS+2 with 8'hFF -> no FIFO change and TXD=8'hzz.
- RST pulse mid-stream with 5 bytes queued in each FIFO -> immediately RX_VALID=0 and TX_READY=1. A following host read returns 8'h00 and sets tx_udf.

Source files
------------

// File: rtl/spi_fifo_port.sv
// rtl/spi_fifo_port.sv - byte-stream FIFO slave for the SPIGate register bus
//
// Purpose: two byte FIFOs share one register address. Host writes (RXE) at
// ADDRESS feed the RX FIFO, which fabric drains through a first-word
// fall-through valid/ready stream. Fabric fills the TX FIFO through a
// valid/ready stream, and host reads (TXE) at ADDRESS drain it.
//
// Optional feature macro: FIFO_PORT_STATUS_EN
//   When defined, ADDRESS+1 is a read-only status register:
//   {tx_udf, rx_ovf, tx_full, tx_empty, rx_full, rx_empty, 2'b00}.
//   A TXE at ADDRESS+1 clears the sticky flags.
//
// Ports:
//   CLK       in   system clock, shared with SPIGate
//   RST       in   asynchronous active-high reset
//   RXD       in   [7:0] host byte, valid with RXE
//   TXD       out  [7:0] tristate byte toward host, driven on decoded ADDR only
//   ADDR      in   [7:0] current transaction register address
//   RXE       in   one-cycle write strobe
//   TXE       in   one-cycle read strobe (advance to next byte)
//   RX_DATA   out  [7:0] RX FIFO head byte
//   RX_VALID  out  RX FIFO not empty
//   RX_READY  in   fabric accepts RX_DATA
//   TX_DATA   in   [7:0] fabric byte
//   TX_VALID  in   fabric offers TX_DATA
//   TX_READY  out  TX FIFO not full

module spi_fifo_port #(
    parameter logic [7:0] ADDRESS    = 8'h10,
    parameter int         DEPTH_LOG2 = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] RXD,
    output logic [7:0] TXD,
    input  logic [7:0] ADDR,
    input  logic       RXE,
    input  logic       TXE,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY
);

    localparam int                    DEPTH    = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            r_rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_rx_wr;
    logic [DEPTH_LOG2-1:0] r_rx_rd;
    logic [DEPTH_LOG2:0]   r_rx_cnt;

    logic [7:0]            r_tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_tx_wr;
    logic [DEPTH_LOG2-1:0] r_tx_rd;
    logic [DEPTH_LOG2:0]   r_tx_cnt;

    logic       w_data_sel;
    logic       w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
    logic       w_rx_wr_req, w_rx_push, w_rx_pop;
    logic       w_tx_rd_req, w_tx_push, w_tx_pop;
    logic [7:0] w_tx_head;

    assign w_data_sel = (ADDR == ADDRESS);

    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == CNT_FULL);
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == CNT_FULL);

    // A full RX FIFO still accepts a host byte when fabric frees a slot in
    // the same cycle; the write lands in the slot being vacated.
    assign w_rx_pop    = !w_rx_empty && RX_READY;
    assign w_rx_wr_req = RXE && w_data_sel;
    assign w_rx_push   = w_rx_wr_req && (!w_rx_full || w_rx_pop);

    assign w_tx_push   = TX_VALID && !w_tx_full;
    assign w_tx_rd_req = TXE && w_data_sel;
    assign w_tx_pop    = w_tx_rd_req && !w_tx_empty;

    assign RX_VALID  = !w_rx_empty;
    assign RX_DATA   = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd];
    assign TX_READY  = !w_tx_full;
    assign w_tx_head = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rd];

    // Storage carries no reset; emptiness is tracked by the counts alone.
    always_ff @(posedge CLK) begin
        if (w_rx_push) r_rx_mem[r_rx_wr] <= RXD;
        if (w_tx_push) r_tx_mem[r_tx_wr] <= TX_DATA;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rx_wr  <= '0;
            r_rx_rd  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wr <= r_rx_wr + PTR_ONE;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + PTR_ONE;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + CNT_ONE;
                2'b01:   r_rx_cnt <= r_rx_cnt - CNT_ONE;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tx_wr  <= '0;
            r_tx_rd  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + PTR_ONE;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + PTR_ONE;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + CNT_ONE;
                2'b01:   r_tx_cnt <= r_tx_cnt - CNT_ONE;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

`ifdef FIFO_PORT_STATUS_EN
    localparam logic [7:0] STATUS_ADDR = ADDRESS + 8'd1;

    logic       r_rx_ovf;
    logic       r_tx_udf;
    logic       w_stat_sel;
    logic       w_stat_clr;
    logic       w_rx_ovf_evt;
    logic       w_tx_udf_evt;
    logic [7:0] w_status;

    assign w_stat_sel   = (ADDR == STATUS_ADDR);
    assign w_stat_clr   = TXE && w_stat_sel;
    assign w_rx_ovf_evt = w_rx_wr_req && !w_rx_push;
    assign w_tx_udf_evt = w_tx_rd_req && w_tx_empty;
    assign w_status     = {r_tx_udf, r_rx_ovf, w_tx_full, w_tx_empty,
                           w_rx_full, w_rx_empty, 2'b00};

    // A new flag event outranks a clear arriving in the same cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rx_ovf <= 1'b0;
            r_tx_udf <= 1'b0;
        end else begin
            if (w_rx_ovf_evt)    r_rx_ovf <= 1'b1;
            else if (w_stat_clr) r_rx_ovf <= 1'b0;
            if (w_tx_udf_evt)    r_tx_udf <= 1'b1;
            else if (w_stat_clr) r_tx_udf <= 1'b0;
        end
    end

    assign TXD = w_data_sel ? w_tx_head : (w_stat_sel ? w_status : 8'hzz);
`else
    assign TXD = w_data_sel ? w_tx_head : 8'hzz;
`endif

endmodule
